// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the pipeline registers.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  // Bubble word held by the load/nop_rst pipeline registers when nop_rst is asserted
  localparam logic [31:0] NOP_INSTR = '1;

  typedef enum logic {
    RUN,
    MULTI
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Combinational load-use comparator: flags an ID source that depends on a load in EX.
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is hard-wired to zero, so a load targeting it never produces a dependency
  assign hazard  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer driving the load and nop_rst strobes of the IF/ID, ID/EX, EX/MEM registers.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = 6
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned STAT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  ex_multi_start,
  input  logic [CNT_W-1:0]      ex_multi_cycles,
  output logic                  pc_load,
  output logic                  ifid_load,
  output logic                  ifid_nop_rst,
  output logic                  idex_load,
  output logic                  idex_nop_rst,
  output logic                  exmem_nop_rst,
  output logic                  busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_stall_cycles,
  output logic [STAT_W-1:0]     stat_flushes,
  output logic [STAT_W-1:0]     stat_bubbles
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_match (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hazard      (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_load       = 1'b1;
    ifid_load     = 1'b1;
    ifid_nop_rst  = 1'b0;
    idex_load     = 1'b1;
    idex_nop_rst  = 1'b0;
    exmem_nop_rst = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_nop_rst = 1'b1;
          idex_nop_rst = 1'b1;
        end else if (ex_multi_start && (ex_multi_cycles >= CNT_W'(2))) begin
          // This cycle is the first of the op; MULTI covers the remaining ones
          state_d       = MULTI;
          cnt_d         = ex_multi_cycles - CNT_W'(2);
          pc_load       = 1'b0;
          ifid_load     = 1'b0;
          idex_load     = 1'b0;
          exmem_nop_rst = 1'b1;
        end else if (load_use) begin
          pc_load      = 1'b0;
          ifid_load    = 1'b0;
          idex_nop_rst = 1'b1;
        end
      end
      MULTI: begin
        pc_load       = 1'b0;
        ifid_load     = 1'b0;
        idex_load     = 1'b0;
        exmem_nop_rst = 1'b1;
        busy          = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_load       = 1'b0;
      ifid_load     = 1'b0;
      ifid_nop_rst  = 1'b0;
      idex_load     = 1'b0;
      idex_nop_rst  = 1'b0;
      exmem_nop_rst = 1'b0;
      busy          = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic              flush;
  logic [STAT_W-1:0] stall_q, flush_q, bubble_q;

  assign flush = (state_q == RUN) && branch_taken && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (!pc_load && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
      if (flush && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
      if ((ifid_nop_rst || idex_nop_rst || exmem_nop_rst) && (bubble_q != '1)) begin
        bubble_q <= bubble_q + STAT_W'(1);
      end
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_flushes      = flush_q;
  assign stat_bubbles      = bubble_q;
`endif

endmodule
